// File: rtl/adder_pkg.sv
// adder_pkg: state encodings shared by the serial arithmetic blocks
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full-adder slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock, LSB first
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   r_cat;
    logic [WIDTH-1:0] r_next;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // new sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts
    assign r_cat  = {fa_sum, r_sh};
    assign r_next = r_cat[WIDTH:1];

    // control FSM with datapath shift registers; outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum   <= r_next;
                        cout  <= fa_cout;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one addition; sampled on rising clk edge.
REQ-005 a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 cin  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking new valid sum/cout.
REQ-010 sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the addition.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE.
REQ-013 IDLE: start=1 SHALL be accepted; latch a, b, cin into internal shift registers and carry flop; clear bit counter; next state RUN.
REQ-014 IDLE: start=0 SHALL leave all state unchanged.
REQ-015 RUN: each cycle SHALL add LSB(a_sh) + LSB(b_sh) + carry flop via one full-adder slice; shift sum bit into MSB of internal result shift register; shift a_sh, b_sh right one bit; update carry flop; increment counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the cycle the counter reaches WIDTH-1, copy the completed result register and final carry into sum/cout; next state DONE.
REQ-017 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-018 Latency: start accepted at edge 0 -> done high and sum/cout valid after edge WIDTH+1.
REQ-019 start while busy=1 (RUN or DONE) SHALL be ignored; captured operands unaffected.
REQ-020 Operand changes on a/b/cin after acceptance SHALL not affect the result.
REQ-021 sum/cout SHALL hold the last result from DONE until the next RUN completion; not modified during RUN.
REQ-022 Back-to-back: start held high continuously SHALL give one addition every WIDTH+2 cycles.
REQ-023 Overflow: carry beyond bit WIDTH-1 SHALL appear only on cout; sum wraps modulo 2^WIDTH.
REQ-024 WIDTH=1 SHALL behave as a registered full adder with 1 RUN cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, shift registers=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; sum/cout read 0.
REQ-027 First start SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-028 FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in shared package adder_pkg for reuse by sibling arithmetic blocks.
REQ-029 Counter width SHALL be $clog2(WIDTH+1), derived locally.
REQ-030 Per-bit arithmetic SHALL instantiate one sub-module full_adder (a, b, cin -> sum, cout), purely combinational.
REQ-031 No combinational path from any input to any output.

Verification
REQ-032 WIDTH=8, a=00 b=00 cin=0, start one cycle -> busy high 9 cycles, done pulse at edge 9, sum=00 cout=0.
REQ-033 WIDTH=8, a=FF b=01 cin=0 -> sum=00 cout=1; a=A5 b=5A cin=1 -> sum=00 cout=1; a=7F b=01 cin=0 -> sum=80 cout=0.
REQ-034 WIDTH=8, start a=12 b=34; pulse start with a=FF b=FF at RUN cycle 3 -> single done, sum=46 cout=0, second start ignored.
REQ-035 WIDTH=8, start a=F0 b=0F; rst_n=0 at RUN cycle 4 for 1 cycle -> no done, sum=00 cout=0; next start a=01 b=01 -> sum=02.
REQ-036 WIDTH=1, exhaustive 8 combinations of a,b,cin -> {cout,sum} equals a+b+cin, done 2 edges after each start.
REQ-037 WIDTH=16, start held high, 4 random operand pairs -> done every 18 cycles, each result matches a+b+cin reference model.
